biu_lsu: RTL



---
 rtl/biu_lsu_if.sv | 30 +++
 rtl/biu_lsu.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/biu_lsu_if.sv
// biu_lsu_if: system-bus signal bundle between the BIU and the bus fabric.
//   bus_req   request, held until ack/err (or timeout)
//   bus_we    write strobe
//   bus_addr  word address, [1:0] = 00
//   bus_wdata lane-replicated store data
//   bus_be    byte enables
//   bus_rdata read data
//   bus_ack   access complete
//   bus_err   access error
// master: the BIU side; slave: the bus/memory side.
interface biu_lsu_if;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [3:0]  bus_be;
   logic [31:0] bus_rdata;
   logic        bus_ack;
   logic        bus_err;

   modport master (
      output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
      input  bus_rdata, bus_ack, bus_err
   );

   modport slave (
      input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
      output bus_rdata, bus_ack, bus_err
   );
endinterface

// File: rtl/biu_lsu.sv
// biu_lsu: bus interface unit for the multi-cycle RV32 core. Serves one
// instruction fetch or load/store at a time, returns the fetched word (ins)
// and right-aligned zero-extended load data (data_biu), and flags
// misalignment and bus access faults for the exception stage.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   if_req, pc       fetch request / address (sampled in IDLE)
//   ls_req, ls_we, ls_size, ls_addr, ls_wdata
//                    load/store request (sampled in IDLE, wins over if_req)
//   ins, data_biu    last fetched instruction / last load data
//   done             one-cycle completion pulse
//   ins_addr_mis, ins_acc_fault, addr_mis, load_acc_fault
//                    fault flags, held until the next accepted request
//   bus              system bus (biu_lsu_if.master)
//
// Parameter TIMEOUT: bus cycles without ack/err before an access fault.
// Optional macro BIU_TIMEOUT_EN enables the timeout counter; without it the
// BUS state waits indefinitely for ack/err.
module biu_lsu #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] pc,
   input  logic        ls_req,
   input  logic        ls_we,
   input  logic [1:0]  ls_size,
   input  logic [31:0] ls_addr,
   input  logic [31:0] ls_wdata,
   output logic [31:0] ins,
   output logic [31:0] data_biu,
   output logic        done,
   output logic        ins_addr_mis,
   output logic        ins_acc_fault,
   output logic        addr_mis,
   output logic        load_acc_fault,
   biu_lsu_if.master   bus
);

   typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

   state_t      state_q, state_d;

   // attributes of the access in flight
   logic        is_fetch_q;
   logic        we_q;
   logic [1:0]  lo_q;
   logic [1:0]  size_q;

   // decoded control from the next-state process
   logic        accept;
   logic        acc_ls;
   logic        mis;
   logic        term;
   logic        fault;
   logic        timeout_hit;

   // request-side datapath
   logic [31:0] addr_n;
   logic [3:0]  be_n;
   logic [31:0] wdata_n;

   // load-return datapath
   logic [31:0] shifted;
   logic [31:0] load_data;

`ifdef BIU_TIMEOUT_EN
   logic [7:0]  cnt_q;

   assign timeout_hit = (state_q == BUS) && (cnt_q == 8'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (accept) begin
         cnt_q <= '0;
      end else if (state_q == BUS && !bus.bus_ack && !bus.bus_err) begin
         cnt_q <= cnt_q + 8'd1;
      end
   end
`else
   logic [7:0]  unused_timeout;

   assign unused_timeout = 8'(TIMEOUT);
   assign timeout_hit    = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      acc_ls  = 1'b0;
      mis     = 1'b0;
      term    = 1'b0;
      fault   = 1'b0;
      case (state_q)
         IDLE: begin
            if (ls_req) begin
               accept = 1'b1;
               acc_ls = 1'b1;
               case (ls_size)
                  2'b00:   mis = 1'b0;
                  2'b01:   mis = ls_addr[0];
                  default: mis = (ls_addr[1:0] != 2'b00);
               endcase
            end else if (if_req) begin
               accept = 1'b1;
               mis    = (pc[1:0] != 2'b00);
            end
            if (accept) state_d = mis ? DONE : BUS;
         end
         BUS: begin
            // err takes precedence over a simultaneous ack
            if (bus.bus_err) begin
               term  = 1'b1;
               fault = 1'b1;
            end else if (bus.bus_ack) begin
               term  = 1'b1;
            end else if (timeout_hit) begin
               term  = 1'b1;
               fault = 1'b1;
            end
            if (term) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // lane steering for stores; loads and fetches read all four bytes
   always_comb begin
      addr_n  = acc_ls ? {ls_addr[31:2], 2'b00} : {pc[31:2], 2'b00};
      be_n    = 4'b1111;
      wdata_n = '0;
      if (acc_ls && ls_we) begin
         case (ls_size)
            2'b00: begin
               be_n    = 4'b0001 << ls_addr[1:0];
               wdata_n = {4{ls_wdata[7:0]}};
            end
            2'b01: begin
               be_n    = ls_addr[1] ? 4'b1100 : 4'b0011;
               wdata_n = {2{ls_wdata[15:0]}};
            end
            default: begin
               be_n    = 4'b1111;
               wdata_n = ls_wdata;
            end
         endcase
      end
   end

   always_comb begin
      shifted = bus.bus_rdata >> {lo_q, 3'b000};
      case (size_q)
         2'b00:   load_data = {24'h0, shifted[7:0]};
         2'b01:   load_data = {16'h0, shifted[15:0]};
         default: load_data = shifted;
      endcase
   end

   assign done = (state_q == DONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         is_fetch_q     <= 1'b0;
         we_q           <= 1'b0;
         lo_q           <= '0;
         size_q         <= '0;
         ins            <= '0;
         data_biu       <= '0;
         ins_addr_mis   <= 1'b0;
         ins_acc_fault  <= 1'b0;
         addr_mis       <= 1'b0;
         load_acc_fault <= 1'b0;
         bus.bus_req    <= 1'b0;
         bus.bus_we     <= 1'b0;
         bus.bus_addr   <= '0;
         bus.bus_wdata  <= '0;
         bus.bus_be     <= '0;
      end else begin
         if (accept) begin
            is_fetch_q     <= !acc_ls;
            we_q           <= acc_ls && ls_we;
            lo_q           <= acc_ls ? ls_addr[1:0] : 2'b00;
            size_q         <= acc_ls ? ls_size : 2'b10;
            ins_addr_mis   <= mis && !acc_ls;
            addr_mis       <= mis && acc_ls;
            ins_acc_fault  <= 1'b0;
            load_acc_fault <= 1'b0;
            if (!mis) begin
               bus.bus_req   <= 1'b1;
               bus.bus_we    <= acc_ls && ls_we;
               bus.bus_addr  <= addr_n;
               bus.bus_wdata <= wdata_n;
               bus.bus_be    <= be_n;
            end
         end
         if (term) begin
            bus.bus_req <= 1'b0;
            bus.bus_we  <= 1'b0;
            if (fault) begin
               if (is_fetch_q) ins_acc_fault  <= 1'b1;
               else            load_acc_fault <= 1'b1;
            end else if (is_fetch_q) begin
               ins <= bus.bus_rdata;
            end else if (!we_q) begin
               data_biu <= load_data;
            end
         end
      end
   end

endmodule
